// File: rtl/shift_add_multiplier.sv
// Iterative shift-and-add multiplier for the execute stage.
// It adds one partial product per clock through a ripple-carry adder built
// from full_adder cells. Signed operands are handled as sign/magnitude: the
// magnitudes are multiplied, and the product is negated once at the end.
// A start/busy/done handshake lets the pipeline controller stall while an
// operation runs.

`timescale 1ns/1ps

// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// WIDTH-bit ripple-carry adder, built as a chain of full_adder cells.
module ripple_carry_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// Top level: the handshake FSM and the datapath.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;   // multiplicand magnitude
  logic [WIDTH-1:0] mplr;    // multiplier magnitude; low half of the accumulator
  logic [WIDTH-1:0] acc_hi;  // high half of the running sum
  logic             neg;     // the final product must be negated
  logic [CW-1:0]    count;   // iteration index within RUN

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum_lo;
  logic             sum_co;
  logic [PW-1:0]    full;

  // Operand magnitudes taken at accept. The most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  // NOTE: every output of an always_comb block gets a default first, so
  // no path through the block can leave a latch behind.
  always_comb begin
    abs_a = a;
    abs_b = b;
    if (op_signed && a[WIDTH-1]) abs_a = ~a + WIDTH'(1);
    if (op_signed && b[WIDTH-1]) abs_b = ~b + WIDTH'(1);
  end

  // The partial product is the multiplicand, gated by the current multiplier LSB.
  assign addend = mplr[0] ? mcand : '0;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum_lo),
    .cout (sum_co)
  );

  // Unsigned magnitude product, available once all iterations are done.
  assign full = {acc_hi, mplr};

  // Control FSM and datapath registers. busy and done are registered.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc_hi  <= '0;
      neg     <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= abs_a;
            mplr   <= abs_b;
            neg    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_hi <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          // Shift {carry, sum, mplr} right by one. The carry-out becomes the
          // new MSB, and the sum's low bit moves into the freed multiplier bit.
          acc_hi <= {sum_co, sum_lo[WIDTH-1:1]};
          mplr   <= {sum_lo[0], mplr[WIDTH-1:1]};
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          product <= neg ? (~full + PW'(1)) : full;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// An 8-bit instance runs table-driven vectors and handshake corner cases.
// A 32-bit instance runs back-to-back random operations against a
// reference model.

`timescale 1ns/1ps

module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8, sg8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start32, sg32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] prod32;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  logic [15:0] sb8[$];
  logic [63:0] sb32[$];
  logic [15:0] last8 = '0;   // product the 8-bit DUT must be holding

  typedef struct {
    logic        sg;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start8),
    .op_signed (sg8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .product   (prod8)
  );

  shift_add_multiplier #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start32),
    .op_signed (sg32),
    .a         (a32),
    .b         (b32),
    .busy      (busy32),
    .done      (done32),
    .product   (prod32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One 8-bit operation: accept, watch busy and hold, then check the result and the done pulse.
  task automatic run8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input string tag);
    int          cyc;
    bit          ok;
    logic [15:0] want;
    @(negedge clk);
    sg8 = sg; a8 = a; b8 = b; start8 = 1'b1;
    sb8.push_back(exp);
    @(posedge clk);                       // accept edge
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
    cyc = 1;
    ok  = 1'b1;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 !== 1'b1 || prod8 !== last8) ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd10);
    check({tag, "_busy_and_hold"}, 64'(ok), 64'd1);
    check({tag, "_busy_low_at_done"}, 64'(busy8), 64'd0);
    want = sb8.pop_front();
    check({tag, "_product"}, 64'(prod8), 64'(want));
    last8 = want;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done8), 64'd0);
    check({tag, "_product_held"}, 64'(prod8), 64'(last8));
  endtask

  // Reference model for the 32-bit instance.
  function automatic logic [63:0] ref32(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] corner[5];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h8000_0000;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h7FFF_FFFF;
    corner[4] = 32'h0000_0001;
    if ($urandom_range(7) == 0) return corner[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, w, prev_done;
    logic [15:0] first_prod;
    logic [63:0] want;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'h008F};
    vecs[1] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
    vecs[2] = '{1'b0, 8'hFD,  8'h05,  16'h04F1};
    vecs[3] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[4] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[5] = '{1'b1, 8'h80,  8'h01,  16'hFF80};
    vecs[6] = '{1'b1, 8'h7F,  8'hFF,  16'hFF81};
    vecs[7] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    vecs[8] = '{1'b0, 8'h00,  8'hC3,  16'h0000};
    vecs[9] = '{1'b0, 8'h80,  8'h02,  16'h0100};

    rst_n = 1'b0;
    start8 = 0; sg8 = 0; a8 = 0; b8 = 0;
    start32 = 0; sg32 = 0; a32 = 0; b32 = 0;
    #3;
    check("reset_busy8", 64'(busy8), 64'd0);
    check("reset_done8", 64'(done8), 64'd0);
    check("reset_prod8", 64'(prod8), 64'd0);
    check("reset_busy32", 64'(busy32), 64'd0);
    check("reset_prod32", prod32, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++)
      run8(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // A start pulse during RUN must be ignored.
    @(negedge clk);
    sg8 = 1'b0; a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    sb8.push_back(16'h008F);
    @(posedge clk);
    @(negedge clk);                       // cycle 1
    start8 = 1'b0;
    repeat (2) @(negedge clk);            // cycle 3, still RUN
    start8 = 1'b1; a8 = 8'd0; b8 = 8'd0;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    first_prod = '0;
    for (int c = 0; c < 25; c++) begin
      if (done8 === 1'b1) begin
        if (ndone == 0) first_prod = prod8;
        ndone++;
      end
      @(negedge clk);
    end
    check("midrun_done_count", 64'(ndone), 64'd1);
    last8 = sb8.pop_front();
    check("midrun_product", 64'(first_prod), 64'(last8));
    check("midrun_product_after", 64'(prod8), 64'(last8));

    // Asynchronous reset after the fourth iteration.
    @(negedge clk);
    sg8 = 1'b0; a8 = 8'h55; b8 = 8'h33; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);            // four iterations completed
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy8), 64'd0);
    check("async_rst_done", 64'(done8), 64'd0);
    check("async_rst_product", 64'(prod8), 64'd0);
    last8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run8(1'b0, 8'd7, 8'd6, 16'h002A, "after_reset");

    // 32-bit back-to-back random operations, with start held high.
    @(negedge clk);
    sg32 = 1'($urandom); a32 = pick32(); b32 = pick32();
    sb32.push_back(ref32(sg32, a32, b32));
    start32 = 1'b1;
    prev_done = -1;
    for (int n = 0; n < 1000; n++) begin
      w = 0;
      while (done32 !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (done32 !== 1'b1) begin
        check($sformatf("w32_op%0d_timeout", n), 64'd0, 64'd1);
        break;
      end
      want = sb32.pop_front();
      check($sformatf("w32_op%0d_product", n), prod32, want);
      if (prev_done >= 0)
        check($sformatf("w32_op%0d_spacing", n), 64'(cyc_cnt - prev_done), 64'd34);
      prev_done = cyc_cnt;
      if (n < 999) begin
        sg32 = 1'($urandom); a32 = pick32(); b32 = pick32();
        sb32.push_back(ref32(sg32, a32, b32));
      end else begin
        start32 = 1'b0;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("w32_idle_after", 64'(busy32), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
